// File: rtl/eth_rx_pkg.sv
// Shared types for the RMII receive frame-commit stage.
package eth_rx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        WAIT_CK = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    typedef logic [1:0] dibit_t;

    // Per-cycle strobes from the FSM to the datapath.
    typedef struct packed {
        logic start;
        logic pack;
        logic good_inc;
        logic bad_inc;
    } fsm_ctl_t;

endpackage

// File: rtl/eth_rx_commit_if.sv
// Dibit ingress, checksum verdict and staged-word egress of the frame-commit stage.
interface eth_rx_commit_if #(parameter int WORD_W = 32);
    import eth_rx_pkg::*;

    logic              axiiv;
    dibit_t            axiid;
    logic              done;
    logic              kill;
    logic              axiov;
    logic [WORD_W-1:0] axiod;
    logic              axiolast;
    logic              axior;

    modport master (
        output axiiv, axiid, done, kill, axior,
        input  axiov, axiod, axiolast
    );

    modport slave (
        input  axiiv, axiid, done, kill, axior,
        output axiov, axiod, axiolast
    );

endinterface

// File: rtl/eth_rx_commit_word_buf.sv
// Per-frame staging store: DEPTH x WORD_W, one write port, one asynchronous read port.
module rx_word_buf #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // NOTE: storage has no reset; a word is only ever read after being written in the same frame.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/eth_rx_commit.sv
// Packs filtered RMII dibits into words, stages one frame, and releases it only on a clean checksum.
module eth_rx_commit
    import eth_rx_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 14,
    parameter int TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             rst,
    eth_rx_commit_if.slave   bus,
    output logic [CNT_W-1:0] good_count,
    output logic [CNT_W-1:0] bad_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             busy
);

    localparam int DIBITS_PER_WORD = WORD_W / 2;
    localparam int PTR_W           = $clog2(DEPTH) + 1;
    localparam int AW              = $clog2(DEPTH);
    localparam int DC_W            = $clog2(DIBITS_PER_WORD);
    localparam int TM_W            = $clog2(TIMEOUT + 1);

    state_t            state, state_nx;
    fsm_ctl_t          ctl;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [WORD_W-3:0] shreg;
    logic [DC_W-1:0]   dib_cnt;
    logic [TM_W-1:0]   timer;
    logic              ovf, done_seen, kill_seen, ignore, axiiv_q;
    logic              drop_hit, done_now, kill_now, word_done, full, last, handshake, we, axiov_r;
    logic [WORD_W-1:0] wdata, rd_data;

    assign drop_hit  = bus.axiiv && !axiiv_q && (state == WAIT_CK || state == DRAIN);
    assign done_now  = done_seen || bus.done;
    assign kill_now  = kill_seen || (bus.done && bus.kill);
    assign word_done = (dib_cnt == DC_W'(DIBITS_PER_WORD - 1));
    assign full      = (wr_ptr == PTR_W'(DEPTH));
    assign last      = (rd_ptr == wr_ptr - PTR_W'(1));
    assign axiov_r   = (state == DRAIN);
    assign handshake = axiov_r && bus.axior;
    assign wdata     = {shreg, bus.axiid};
    // Words beyond DEPTH are dropped here; the frame is already doomed by ovf.
    assign we        = ctl.pack && word_done && !full;

    rx_word_buf #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_buf (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wdata),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_data)
    );

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        ctl      = '0;
        unique case (state)
            IDLE: begin
                if (bus.axiiv && !ignore) begin
                    ctl.start = 1'b1;
                    state_nx  = FILL;
                end
            end
            FILL: begin
                if (bus.axiiv) ctl.pack = 1'b1;
                else           state_nx = WAIT_CK;
            end
            WAIT_CK: begin
                if (done_now) begin
                    if (kill_now || ovf || wr_ptr == '0) begin
                        ctl.bad_inc = 1'b1;
                        state_nx    = IDLE;
                    end else begin
                        ctl.good_inc = 1'b1;
                        state_nx     = DRAIN;
                    end
                end else if (timer == TM_W'(TIMEOUT - 1)) begin
                    ctl.bad_inc = 1'b1;
                    state_nx    = IDLE;
                end
            end
            DRAIN: begin
                if (handshake && last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            shreg      <= '0;
            dib_cnt    <= '0;
            timer      <= '0;
            ovf        <= 1'b0;
            done_seen  <= 1'b0;
            kill_seen  <= 1'b0;
            ignore     <= 1'b0;
            axiiv_q    <= 1'b0;
            good_count <= '0;
            bad_count  <= '0;
            drop_count <= '0;
        end else begin
            state   <= state_nx;
            axiiv_q <= bus.axiiv;
            // A frame that began while busy stays ignored until its axiiv falls.
            ignore  <= bus.axiiv && (ignore || drop_hit);

            if (ctl.good_inc && good_count != '1) good_count <= good_count + CNT_W'(1);
            if (ctl.bad_inc  && bad_count  != '1) bad_count  <= bad_count  + CNT_W'(1);
            if (drop_hit     && drop_count != '1) drop_count <= drop_count + CNT_W'(1);

            unique case (state)
                IDLE: begin
                    wr_ptr    <= '0;
                    rd_ptr    <= '0;
                    timer     <= '0;
                    ovf       <= 1'b0;
                    done_seen <= 1'b0;
                    kill_seen <= 1'b0;
                    shreg     <= {{(WORD_W - 4){1'b0}}, bus.axiid};
                    dib_cnt   <= DC_W'(ctl.start);
                end
                FILL: begin
                    done_seen <= done_now;
                    kill_seen <= kill_now;
                    if (ctl.pack) begin
                        shreg   <= wdata[WORD_W-3:0];
                        dib_cnt <= word_done ? '0 : dib_cnt + DC_W'(1);
                        if (word_done) begin
                            if (full) ovf    <= 1'b1;
                            else      wr_ptr <= wr_ptr + PTR_W'(1);
                        end
                    end
                end
                WAIT_CK: begin
                    done_seen <= done_now;
                    kill_seen <= kill_now;
                    timer     <= timer + TM_W'(1);
                    rd_ptr    <= '0;
                end
                DRAIN: begin
                    if (handshake) rd_ptr <= rd_ptr + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.axiov    = axiov_r;
    assign bus.axiod    = axiov_r ? rd_data : '0;
    assign bus.axiolast = axiov_r && last;
    assign busy         = (state != IDLE);

endmodule
